// File: rtl/sensor_pkg.sv
// Shared constants and IR state encoding for the sensor front end.
package sensor_pkg;

  localparam int unsigned DefDebounceCycles = 1000;
  localparam int unsigned DefIrHoldCycles   = 50000;
  localparam int unsigned DefLostCycles     = 100000;

  localparam logic [1:0] IpsResetVal = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDetect = 2'd1,
    StHold   = 2'd2
  } ir_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a saturating-free debounce counter for one input pin.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o,
  output logic filt_next_o
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [1:0]      prime_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counting waits until the synchronizer holds real samples, so the
  // reset-zero flops never count against a reset value of 1.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (prime_q[1] && (sync2_q != filt_q)) begin
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prime_q <= 2'b00;
      filt_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o      = filt_q;
  assign filt_next_o = filt_d;

endmodule

// File: rtl/sensor_frontend.sv
// Line/obstacle sensor conditioning: debounce, IR hold stretch, line-lost timer, update pulse.
module sensor_frontend
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned IR_HOLD_CYCLES  = DefIrHoldCycles,
  parameter int unsigned LOST_CYCLES     = DefLostCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_IPS,
  input  logic       raw_midIPS,
  input  logic       raw_IR,
  output logic [1:0] IPS,
  output logic       midIPS,
  output logic       IR,
  output logic       line_lost,
  output logic       sensor_update
);

  localparam int unsigned      HoldW    = $clog2(IR_HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(IR_HOLD_CYCLES - 1);
  localparam int unsigned      LostW    = $clog2(LOST_CYCLES + 1);
  localparam logic [LostW-1:0] LostMax  = LostW'(LOST_CYCLES);
  localparam logic [3:0]       ChReset  = {IpsResetVal, 1'b0, 1'b0};

  // Channel order: {IPS[1], IPS[0], midIPS, IR}.
  logic [3:0] ch_raw, ch_filt, ch_next;
  assign ch_raw = {raw_IPS, raw_midIPS, raw_IR};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (ChReset[i])
    ) u_debounce (
      .clk_i      (clk),
      .rst_ni     (reset),
      .raw_i      (ch_raw[i]),
      .filt_o     (ch_filt[i]),
      .filt_next_o(ch_next[i])
    );
  end

  assign IPS    = ch_filt[3:2];
  assign midIPS = ch_filt[1];

  // The FSM follows the IR channel's next value so IR moves on the same
  // edge the filtered bit does.
  logic ir_next;
  assign ir_next = ch_next[0];

  logic unused_ch;
  assign unused_ch = ^{ch_next[3:1], ch_filt[0]};

  ir_state_e        state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        hold_d = '0;
        if (ir_next) state_d = StDetect;
      end
      StDetect: begin
        hold_d = '0;
        if (!ir_next) state_d = StHold;
      end
      StHold: begin
        if (ir_next) begin
          state_d = StDetect;
          hold_d  = '0;
        end else if (hold_q == HoldLast) begin
          state_d = StIdle;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    IR = (state_q != StIdle);
  end

  logic [LostW-1:0] lost_q, lost_d;

  always_comb begin
    lost_d = '0;
    if ((IPS == 2'b00) && !midIPS) begin
      lost_d = (lost_q == LostMax) ? lost_q : lost_q + LostW'(1);
    end
  end

  logic [3:0] cur_out, prev_q;
  logic       upd_q;
  assign cur_out = {IPS, midIPS, IR};

  always_ff @(posedge clk) begin
    if (!reset) begin
      lost_q <= '0;
      prev_q <= {IpsResetVal, 1'b0, 1'b0};
      upd_q  <= 1'b0;
    end else begin
      lost_q <= lost_d;
      prev_q <= cur_out;
      upd_q  <= (cur_out != prev_q);
    end
  end

  assign line_lost     = (lost_q == LostMax);
  assign sensor_update = upd_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend with small debounce, hold and lost windows.
module tb_sensor_frontend;

  localparam int unsigned Db   = 4;
  localparam int unsigned Hold = 8;
  localparam int unsigned Lost = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] raw_IPS;
  logic       raw_midIPS;
  logic       raw_IR;
  logic [1:0] IPS;
  logic       midIPS;
  logic       IR;
  logic       line_lost;
  logic       sensor_update;

  sensor_frontend #(
    .DEBOUNCE_CYCLES(Db),
    .IR_HOLD_CYCLES (Hold),
    .LOST_CYCLES    (Lost)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_IPS      (raw_IPS),
    .raw_midIPS   (raw_midIPS),
    .raw_IR       (raw_IR),
    .IPS          (IPS),
    .midIPS       (midIPS),
    .IR           (IR),
    .line_lost    (line_lost),
    .sensor_update(sensor_update)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ips;
    logic       mid;
    logic       ir;
    int         wait_cyc;
    logic [1:0] e_ips;
    logic       e_mid;
    logic       e_ir;
    logic       e_lost;
    logic       e_upd;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_ips, input logic e_mid,
                         input logic e_ir, input logic e_lost, input logic e_upd);
    chk({tag, ".IPS"}, 32'(IPS), 32'(e_ips));
    chk({tag, ".midIPS"}, 32'(midIPS), 32'(e_mid));
    chk({tag, ".IR"}, 32'(IR), 32'(e_ir));
    chk({tag, ".line_lost"}, 32'(line_lost), 32'(e_lost));
    chk({tag, ".sensor_update"}, 32'(sensor_update), 32'(e_upd));
  endtask

  initial begin
    // inputs                      wait  IPS    mid   IR    lost  upd
    vecs[0]  = '{2'b10, 1'b0, 1'b0, 5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 1'b0, 1'b0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 1'b0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 1'b0, 1'b0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 1'b0, 3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2'b00, 1'b1, 1'b0, 5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 1'b1, 1'b0, 1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{2'b00, 1'b1, 1'b0, 1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{2'b00, 1'b1, 1'b0, 1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'b11, 1'b0, 1'b0, 6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{2'b11, 1'b0, 1'b0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{2'b11, 1'b0, 1'b0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};

    reset      = 1'b0;
    raw_IPS    = 2'b11;
    raw_midIPS = 1'b0;
    raw_IR     = 1'b0;
    step(3);
    chk_all("reset", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_all($sformatf("idle%0d", i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Line sensors, lost timer and combined update pulse.
    for (int i = 0; i < 17; i++) begin
      raw_IPS    = vecs[i].ips;
      raw_midIPS = vecs[i].mid;
      raw_IR     = vecs[i].ir;
      step(vecs[i].wait_cyc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ips, vecs[i].e_mid, vecs[i].e_ir,
              vecs[i].e_lost, vecs[i].e_upd);
    end

    // Three-cycle glitch on the centre sensor must be swallowed.
    raw_midIPS = 1'b1;
    step(3);
    raw_midIPS = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("glitch%0d.midIPS", i), 32'(midIPS), 32'd0);
      chk($sformatf("glitch%0d.upd", i), 32'(sensor_update), 32'd0);
    end

    // IR high for 10 cycles: rise after Db+2, then Hold cycles of stretch.
    raw_IR = 1'b1;
    step(5);
    chk("ir1_pre", 32'(IR), 32'd0);
    step(1);
    chk("ir1_rise", 32'(IR), 32'd1);
    step(1);
    chk("ir1_rise_upd", 32'(sensor_update), 32'd1);
    step(3);
    raw_IR = 1'b0;
    step(13);
    chk("ir1_hold_last", 32'(IR), 32'd1);
    step(1);
    chk("ir1_fall", 32'(IR), 32'd0);
    step(1);
    chk("ir1_fall_upd", 32'(sensor_update), 32'd1);
    step(1);
    chk("ir1_fall_upd_end", 32'(sensor_update), 32'd0);

    // Obstacle returns while in HOLD: re-enter DETECT, IR never drops.
    raw_IR = 1'b1;
    step(6);
    chk("ir2_rise", 32'(IR), 32'd1);
    step(4);
    raw_IR = 1'b0;
    step(4);
    raw_IR = 1'b1;
    step(2);
    chk("ir2_hold", 32'(IR), 32'd1);
    step(6);
    chk("ir2_redetect", 32'(IR), 32'd1);
    raw_IR = 1'b0;
    step(2);
    chk("ir2_no_expire", 32'(IR), 32'd1);
    chk("ir2_no_upd", 32'(sensor_update), 32'd0);
    step(11);
    chk("ir2_hold_last", 32'(IR), 32'd1);
    step(1);
    chk("ir2_fall", 32'(IR), 32'd0);
    step(2);

    // Reset while IR is in HOLD and IPS[1] is mid-debounce.
    raw_IR = 1'b1;
    step(6);
    chk("rst_ir_rise", 32'(IR), 32'd1);
    raw_IR = 1'b0;
    step(4);
    raw_IPS = 2'b01;
    step(4);
    chk("rst_in_hold", 32'(IR), 32'd1);
    reset = 1'b0;
    step(1);
    chk_all("rst_mid", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    reset   = 1'b1;
    raw_IPS = 2'b11;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk_all($sformatf("post_rst%0d", i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Input already changed during reset: first change still takes Db+2.
    reset   = 1'b0;
    raw_IPS = 2'b01;
    step(2);
    reset = 1'b1;
    step(5);
    chk("rel_pre", 32'(IPS), 32'(2'b11));
    step(1);
    chk("rel_change", 32'(IPS), 32'(2'b01));
    step(1);
    chk("rel_upd", 32'(sensor_update), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_frontend.md
SENSOR_FRONTEND -- requirements
Module: sensor_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: consecutive cycles a synchronized input must differ from its filtered output before the output changes; legal range >= 1.
REQ-002 Parameter IR_HOLD_CYCLES, default 50000: minimum cycles IR stays asserted after the filtered obstacle input clears; legal range >= 1.
REQ-003 Parameter LOST_CYCLES, default 100000: consecutive all-dark cycles before line_lost asserts; legal range >= 1.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-006 raw_IPS  input  2  asynchronous left/right line sensor pins.
REQ-007 raw_midIPS  input  1  asynchronous centre line sensor pin.
REQ-008 raw_IR  input  1  asynchronous obstacle sensor pin, 1 = obstacle.
REQ-009 IPS  output  2  filtered left/right line state, drives motor_mv IPS.
REQ-010 midIPS  output  1  filtered centre line state, drives motor_mv midIPS.
REQ-011 IR  output  1  filtered, hold-stretched obstacle flag, drives motor_mv IR.
REQ-012 line_lost  output  1  level: all line sensors dark for LOST_CYCLES cycles.
REQ-013 sensor_update  output  1  one-cycle pulse when IPS, midIPS or IR changes.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each of the four channels (IPS[1], IPS[0], midIPS, IR-raw) SHALL own a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-016 Debounce: counter increments each cycle synced input != filtered bit; clears in any cycle they are equal; when counter reaches DEBOUNCE_CYCLES the filtered bit takes the synced value and counter clears in the same cycle.
REQ-017 Latency raw edge -> IPS/midIPS change SHALL be exactly DEBOUNCE_CYCLES+2 cycles for a clean edge; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-018 IR FSM states: IDLE (IR=0), DETECT (IR=1), HOLD (IR=1, hold counter running).
REQ-019 IDLE -> DETECT when filtered obstacle bit becomes 1.
REQ-020 DETECT -> HOLD when filtered obstacle bit becomes 0; hold counter loads 0.
REQ-021 HOLD: counter increments each cycle; HOLD -> DETECT if filtered obstacle bit returns to 1 (counter cleared); HOLD -> IDLE when counter reaches IR_HOLD_CYCLES-1, IR deasserting the following cycle, giving exactly IR_HOLD_CYCLES cycles of stretch.
REQ-022 Lost counter increments while IPS==2'b00 and midIPS==0; clears in any cycle either condition fails; saturates at LOST_CYCLES.
REQ-023 line_lost SHALL be 1 exactly while lost counter == LOST_CYCLES; it deasserts the cycle after any filtered line bit becomes 1.
REQ-024 sensor_update SHALL pulse one cycle after any registered change of {IPS, midIPS, IR}; simultaneous changes give one pulse.
REQ-025 Counters SHALL never wrap; all compares use counter width, no truncation.

Reset
REQ-026 While reset==0 at a rising edge: synchronizer flops 0, IPS=2'b11, midIPS=0, IR=0, FSM=IDLE, line_lost=0, sensor_update=0, all counters 0.
REQ-027 Reset asserted mid-debounce or in HOLD SHALL abort that operation immediately; no pending change is applied after release.
REQ-028 First output change after reset release SHALL require full DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-029 Package sensor_pkg SHALL hold default parameter constants, IR FSM state encoding (IDLE=2'd0, DETECT=2'd1, HOLD=2'd2) and IPS reset value 2'b11.
REQ-030 Sub-module sensor_debounce (synchronizer + debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times; FSM, lost counter and update pulse stay in the top.
REQ-031 Target size 150-300 RTL lines total.

Verification (DEBOUNCE_CYCLES=4, IR_HOLD_CYCLES=8, LOST_CYCLES=6)
REQ-032 Reset held 3 cycles then released, raw inputs static at reset values -> IPS=2'b11, midIPS=0, IR=0, line_lost=0, no sensor_update pulse for 20 cycles.
REQ-033 raw_IPS 2'b11->2'b10 held -> IPS=2'b10 exactly 6 cycles after edge, sensor_update one-cycle pulse the following cycle.
REQ-034 raw_midIPS 3-cycle high glitch -> midIPS stays 0, no sensor_update.
REQ-035 raw_IR high 10 cycles then low -> IR rises 6 cycles after rising edge, stays 1 for 8 cycles past filtered fall; second 2-cycle-late pulse in HOLD re-enters DETECT.
REQ-036 raw_IPS=2'b00, raw_midIPS=0 held -> line_lost asserts 6 cycles after IPS reaches 2'b00; raw_midIPS=1 -> line_lost drops one cycle after midIPS rises.
REQ-037 Reset pulsed during HOLD and mid-debounce -> next cycle all outputs at reset values, no late transitions.
